// File: rtl/mem_responder.sv
// mem_responder -- single-port 32-bit word memory behind a request/response
// handshake. It models the memory side of a MAR/MDR datapath.
//
// Each access is accepted in IDLE. It then spends WAIT_CYCLES cycles in WAIT
// and completes in a single RESP cycle, during which ready is high.
//
// Parameters:
//   ADDR_W      word-address width (2**ADDR_W words)
//   WAIT_CYCLES wait states between acceptance and response (0..15)
//
// Ports:
//   clk        rising-edge clock
//   clr        asynchronous active-low reset
//   req_read   read request  (memory word -> rdata)
//   req_write  write request (wdata -> memory); wins if both are high
//   addr       word address
//   wdata      write data
//   rdata      last completed read value, held across writes
//   ready      one-cycle completion pulse (the RESP cycle)
//   busy       high in WAIT and RESP
//   err        one-cycle protocol-error pulse; only when MEM_RESPONDER_ERR_EN
//              is defined, otherwise tied 0
//
// Optional feature macro: MEM_RESPONDER_ERR_EN
module mem_responder #(
   parameter int ADDR_W      = 9,
   parameter int WAIT_CYCLES = 2
) (
   input  logic              clk,
   input  logic              clr,
   input  logic              req_read,
   input  logic              req_write,
   input  logic [ADDR_W-1:0] addr,
   input  logic [31:0]       wdata,
   output logic [31:0]       rdata,
   output logic              ready,
   output logic              busy,
   output logic              err
);

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t            state;
   logic [3:0]        cnt;
   logic [ADDR_W-1:0] addrQ;
   logic [31:0]       wdataQ;
   logic              opWrite;

   logic [31:0] mem [2**ADDR_W];

   logic              anyReq;
   logic              goResp;
   logic              accWrite;
   logic [ADDR_W-1:0] accAddr;
   logic [31:0]       accData;

   assign anyReq = req_read | req_write;

   // The access is carried out on the edge that enters RESP. The results
   // (rdata and ready) are therefore valid during the RESP cycle itself.
   // With zero wait states that edge is the acceptance edge. In that case the
   // operands come straight from the inputs, not from the latches.
   always_comb begin
      goResp   = 1'b0;
      accWrite = opWrite;
      accAddr  = addrQ;
      accData  = wdataQ;
      if (state == IDLE) begin
         goResp   = anyReq && (WAIT_CYCLES == 0);
         accWrite = req_write;
         accAddr  = addr;
         accData  = wdata;
      end else if (state == WAIT) begin
         goResp = (cnt == 4'd1);
      end
   end

   // The array has no reset, so its contents survive clr. The write is gated
   // by clr so that a reset held across an edge abandons the access.
   always_ff @(posedge clk) begin
      if (clr && goResp && accWrite)
         mem[accAddr] <= accData;
   end

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         state   <= IDLE;
         cnt     <= 4'd0;
         addrQ   <= '0;
         wdataQ  <= 32'd0;
         opWrite <= 1'b0;
         rdata   <= 32'd0;
         ready   <= 1'b0;
         busy    <= 1'b0;
      end else begin
         ready <= goResp;
         if (goResp && !accWrite)
            rdata <= mem[accAddr];
         case (state)
            IDLE: if (anyReq) begin
               addrQ   <= addr;
               wdataQ  <= wdata;
               opWrite <= req_write;
               cnt     <= 4'(WAIT_CYCLES);
               state   <= (WAIT_CYCLES == 0) ? RESP : WAIT;
               busy    <= 1'b1;
            end
            WAIT: begin
               cnt <= cnt - 4'd1;
               if (cnt == 4'd1) state <= RESP;
            end
            RESP: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

`ifdef MEM_RESPONDER_ERR_EN
   // Two cases are flagged: a request arriving while busy, and a request
   // that has both read and write set at acceptance.
   always_ff @(posedge clk or negedge clr) begin
      if (!clr)
         err <= 1'b0;
      else
         err <= ((state != IDLE) && anyReq) ||
                ((state == IDLE) && req_read && req_write);
   end
`else
   assign err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;

   // Index 0: DUT built with WAIT_CYCLES=0. Index 1: DUT built with WAIT_CYCLES=2.
   logic              clk = 1'b0;
   logic              clr = 1'b1;
   logic [1:0]        rr  = '0;
   logic [1:0]        rw  = '0;
   logic [1:0][8:0]   ad  = '0;
   logic [1:0][31:0]  wd  = '0;
   logic [1:0][31:0]  rd;
   logic [1:0]        rdy, bsy, er;

`ifdef MEM_RESPONDER_ERR_EN
   localparam int ERR_EN = 1;
`else
   localparam int ERR_EN = 0;
`endif

   int checks = 0;
   int errors = 0;

   // Reference model: the latency of each DUT, its memory image and its last
   // completed read value.
   int          lat [2] = '{1, 3};
   logic [31:0] mdl [2][512];
   logic [31:0] lastRd [2];

   mem_responder #(.ADDR_W(9), .WAIT_CYCLES(0)) dut0 (
      .clk(clk), .clr(clr), .req_read(rr[0]), .req_write(rw[0]), .addr(ad[0]),
      .wdata(wd[0]), .rdata(rd[0]), .ready(rdy[0]), .busy(bsy[0]), .err(er[0]));

   mem_responder #(.ADDR_W(9), .WAIT_CYCLES(2)) dut2 (
      .clk(clk), .clr(clr), .req_read(rr[1]), .req_write(rw[1]), .addr(ad[1]),
      .wdata(wd[1]), .rdata(rd[1]), .ready(rdy[1]), .busy(bsy[1]), .err(er[1]));

   always #5 clk = ~clk;

   // Present a request at a negedge, hold it across exactly one rising edge,
   // and update the model with the expected effect.
   task automatic issue(input int s, input bit r, input bit w,
                        input logic [8:0] a, input logic [31:0] d);
      rr[s] = r; rw[s] = w; ad[s] = a; wd[s] = d;
      @(posedge clk);
      #1 rr[s] = 1'b0; rw[s] = 1'b0;
      if (w) mdl[s][a] = d;
      else if (r) lastRd[s] = mdl[s][a];
   endtask

   // Sample n cycles at negedges. Cycle k is the k-th cycle after the last
   // rising edge.
   task automatic observe(input int s, input int n, output int rFirst,
                          output int rCnt, output int bCnt, output int eCnt);
      rFirst = 0; rCnt = 0; bCnt = 0; eCnt = 0;
      for (int k = 1; k <= n; k++) begin
         @(negedge clk);
         if (rdy[s]) begin rCnt++; if (rFirst == 0) rFirst = k; end
         if (bsy[s]) bCnt++;
         if (er[s])  eCnt++;
      end
   endtask

   task automatic test_reset;
      #3 clr = 1'b0;
      repeat (3) @(negedge clk);
      clr = 1'b1;
      lastRd[0] = 32'd0; lastRd[1] = 32'd0;
      @(negedge clk);
      for (int s = 0; s < 2; s++) begin
         checks++; if (rd[s] !== 32'd0) begin errors++; $display("FAIL reset_rdata[%0d] got %h want 0", s, rd[s]); end
         checks++; if (rdy[s] !== 1'b0) begin errors++; $display("FAIL reset_ready[%0d] got %b want 0", s, rdy[s]); end
         checks++; if (bsy[s] !== 1'b0) begin errors++; $display("FAIL reset_busy[%0d] got %b want 0", s, bsy[s]); end
         checks++; if (er[s]  !== 1'b0) begin errors++; $display("FAIL reset_err[%0d] got %b want 0", s, er[s]); end
      end
   endtask

   task automatic test_write_read;
      int f, rc, bc, ec;
      issue(1, 1'b0, 1'b1, 9'h005, 32'hDEADBEEF);
      observe(1, 5, f, rc, bc, ec);
      checks++; if (f !== 3 || rc !== 1) begin errors++; $display("FAIL wr_ready first=%0d cnt=%0d want 3/1", f, rc); end
      checks++; if (bc !== 3) begin errors++; $display("FAIL wr_busy got %0d want 3", bc); end
      checks++; if (rd[1] !== lastRd[1]) begin errors++; $display("FAIL wr_rdata_hold got %h want %h", rd[1], lastRd[1]); end
      issue(1, 1'b1, 1'b0, 9'h005, 32'h0);
      observe(1, 5, f, rc, bc, ec);
      checks++; if (f !== 3 || rc !== 1) begin errors++; $display("FAIL rd_ready first=%0d cnt=%0d want 3/1", f, rc); end
      checks++; if (rd[1] !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_rdata got %h want deadbeef", rd[1]); end
      checks++; if (ec !== 0) begin errors++; $display("FAIL rd_err got %0d want 0", ec); end
   endtask

   task automatic test_zero_wait;
      int f, rc, bc, ec;
      issue(0, 1'b0, 1'b1, 9'h1FF, 32'h12345678);
      observe(0, 3, f, rc, bc, ec);
      issue(0, 1'b1, 1'b0, 9'h1FF, 32'h0);
      observe(0, 3, f, rc, bc, ec);
      checks++; if (f !== 1 || rc !== 1) begin errors++; $display("FAIL zw_ready first=%0d cnt=%0d want 1/1", f, rc); end
      checks++; if (bc !== 1) begin errors++; $display("FAIL zw_busy got %0d want 1", bc); end
      checks++; if (rd[0] !== 32'h12345678) begin errors++; $display("FAIL zw_rdata got %h want 12345678", rd[0]); end
   endtask

   task automatic test_busy_ignore;
      int f, rc, bc, ec, e1;
      logic [31:0] pre;
      pre = $urandom;
      issue(1, 1'b0, 1'b1, 9'h010, pre);
      observe(1, 5, f, rc, bc, ec);
      issue(1, 1'b1, 1'b0, 9'h010, 32'h0);
      @(negedge clk);                       // cycle 1: the DUT is in WAIT
      e1 = int'(er[1]);
      rw[1] = 1'b1; ad[1] = 9'h011; wd[1] = 32'hFFFFFFFF;
      @(posedge clk);
      #1 rw[1] = 1'b0;
      observe(1, 5, f, rc, bc, ec);
      checks++; if (f !== 2 || rc !== 1) begin errors++; $display("FAIL busy_ready first=%0d cnt=%0d want 2/1", f, rc); end
      checks++; if (e1 + ec !== ERR_EN) begin errors++; $display("FAIL busy_err got %0d want %0d", e1 + ec, ERR_EN); end
      checks++; if (rd[1] !== pre) begin errors++; $display("FAIL busy_rdata got %h want %h", rd[1], pre); end
      issue(1, 1'b1, 1'b0, 9'h010, 32'h0);
      observe(1, 5, f, rc, bc, ec);
      checks++; if (rd[1] !== pre) begin errors++; $display("FAIL busy_mem got %h want %h", rd[1], pre); end
   endtask

   task automatic test_both_req;
      int f, rc, bc, ec;
      logic [31:0] hold;
      hold = lastRd[1];
      issue(1, 1'b1, 1'b1, 9'h020, 32'h0000ABCD);
      observe(1, 5, f, rc, bc, ec);
      checks++; if (ec !== ERR_EN) begin errors++; $display("FAIL both_err got %0d want %0d", ec, ERR_EN); end
      checks++; if (rd[1] !== hold) begin errors++; $display("FAIL both_rdata got %h want %h", rd[1], hold); end
      issue(1, 1'b1, 1'b0, 9'h020, 32'h0);
      observe(1, 5, f, rc, bc, ec);
      checks++; if (rd[1] !== 32'h0000ABCD) begin errors++; $display("FAIL both_mem got %h want 0000abcd", rd[1]); end
   endtask

   task automatic test_reset_mid;
      int f, rc, bc, ec;
      issue(1, 1'b0, 1'b1, 9'h030, 32'h11111111);
      observe(1, 5, f, rc, bc, ec);
      issue(1, 1'b0, 1'b1, 9'h030, 32'h55AA55AA);
      mdl[1][9'h030] = 32'h11111111;        // the write is abandoned
      @(negedge clk);
      clr = 1'b0;
      #1;
      checks++; if (bsy[1] !== 1'b0 || rdy[1] !== 1'b0) begin errors++; $display("FAIL mid_reset busy=%b ready=%b want 0/0", bsy[1], rdy[1]); end
      repeat (2) @(negedge clk);
      clr = 1'b1;
      lastRd[0] = 32'd0; lastRd[1] = 32'd0;
      observe(1, 5, f, rc, bc, ec);
      checks++; if (rc !== 0) begin errors++; $display("FAIL mid_ready got %0d want 0", rc); end
      issue(1, 1'b1, 1'b0, 9'h030, 32'h0);
      observe(1, 5, f, rc, bc, ec);
      checks++; if (rd[1] !== 32'h11111111) begin errors++; $display("FAIL mid_mem got %h want 11111111", rd[1]); end
   endtask

   task automatic test_random;
      int f, rc, bc, ec, s;
      logic [8:0] a;
      logic w;
      for (int i = 0; i < 16; i++) begin    // write every address the loop reads
         s = i % 2;
         issue(s, 1'b0, 1'b1, 9'(9'h040 + (i / 2) * 3), $urandom);
         observe(s, 5, f, rc, bc, ec);
      end
      for (int i = 0; i < 40; i++) begin
         s = int'($urandom_range(0, 1));
         a = 9'(9'h040 + $urandom_range(0, 7) * 3);
         w = 1'($urandom_range(0, 1));
         issue(s, !w, w, a, $urandom);
         observe(s, 5, f, rc, bc, ec);
         checks++; if (f !== lat[s] || rc !== 1) begin errors++; $display("FAIL rnd_ready[%0d] first=%0d cnt=%0d want %0d/1", s, f, rc, lat[s]); end
         checks++; if (rd[s] !== lastRd[s]) begin errors++; $display("FAIL rnd_rdata[%0d] got %h want %h", s, rd[s], lastRd[s]); end
      end
   endtask

   initial begin
      test_reset;
      test_write_read;
      test_zero_wait;
      test_busy_ignore;
      test_both_req;
      test_reset_mid;
      test_random;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
